array_mult_server: RTL and testbench

Time-multiplexed responder for the Jacobian array-multiplier port. It accepts nine 27-bit signed fixed-point operand pairs on `array_mult_dataa`/`array_mult_datab` and computes the nine products on a reduced number of physical multipliers (default 3). It returns the products on `array_mult_result` through a start/done handshake. It sits between the Jacobian datapath and the DSP resources, and replaces a nine-DSP combinational bank.

---
 rtl/array_mult_server.sv | 187 ++++++++++++++++++
 tb/tb_array_mult_server.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/array_mult_server.sv
// array_mult_server: nine-lane Q8.18 multiply server for the Jacobian datapath.
// Products are computed PHYS lanes at a time on a PIPE-deep multiplier
// pipeline, collected in a staging register, and published on done.
//
// Handshake: start is sampled only in IDLE with en high. busy is high from the
// cycle after acceptance through the done cycle. done is a one-cycle pulse
// that coincides with the first cycle the new result/overflow are visible.
// en low freezes every register and masks done, so a pending done appears
// once en returns.
module array_mult_server #(
  parameter int LANES = 9,
  parameter int WIDTH = 27,
  parameter int FRAC  = 18,
  parameter int PHYS  = 3,
  parameter int PIPE  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         start,
  input  logic [LANES-1:0][WIDTH-1:0]  array_mult_dataa,
  input  logic [LANES-1:0][WIDTH-1:0]  array_mult_datab,
  output logic [LANES-1:0][WIDTH-1:0]  array_mult_result,
  output logic [LANES-1:0]             overflow,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   state_dbg
);

  localparam int GROUPS = LANES / PHYS;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW     = 2 * WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [GW-1:0] LAST_G = GW'(GROUPS - 1);

  // Saturation bounds expressed at full product width.
  localparam logic signed [PW-1:0] MAX_V = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_V = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef logic [LANES-1:0][WIDTH-1:0] lanes_t;

  logic [1:0]                       state_q, state_d;
  logic [GW-1:0]                    grp_q, grp_d;
  lanes_t                           a_q, a_d, b_q, b_d;
  logic [PIPE-1:0]                  pv_q, pv_d;
  logic [PIPE-1:0][GW-1:0]          ptag_q, ptag_d;
  logic [PIPE-1:0][PHYS-1:0][PW-1:0] pprod_q, pprod_d;
  lanes_t                           stage_res_q, stage_res_d;
  logic [LANES-1:0]                 stage_ovf_q, stage_ovf_d;
  lanes_t                           result_q, result_d;
  logic [LANES-1:0]                 ovf_q, ovf_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;

  // Floor shift by FRAC, then clamp to WIDTH bits; MSB of the return is the overflow flag.
  function automatic logic [WIDTH:0] saturate(input logic [PW-1:0] prod);
    logic signed [PW-1:0] sh;
    sh = $signed(prod) >>> FRAC;
    if (sh > MAX_V)      saturate = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
    else if (sh < MIN_V) saturate = {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
    else                 saturate = {1'b0, sh[WIDTH-1:0]};
  endfunction

  // Next-state: FSM, operand capture, multiplier pipeline, staging and outputs.
  always_comb begin
    logic [LW-1:0]          idx;
    logic signed [PW-1:0]   ea;
    logic signed [PW-1:0]   eb;
    state_d     = state_q;
    grp_d       = grp_q;
    a_d         = a_q;
    b_d         = b_q;
    pv_d        = pv_q;
    ptag_d      = ptag_q;
    pprod_d     = pprod_q;
    stage_res_d = stage_res_q;
    stage_ovf_d = stage_ovf_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    busy_d      = busy_q;
    done_d      = done_q;
    idx         = '0;
    ea          = '0;
    eb          = '0;
    if (en) begin
      done_d = (state_q == S_DONE);
      if (done_q) busy_d = 1'b0;

      // First stage takes the current group; later stages shift along.
      pv_d[0]   = (state_q == S_ISSUE);
      ptag_d[0] = grp_q;
      for (int p = 0; p < PHYS; p++) begin
        idx = LW'(int'(grp_q) * PHYS + p);
        ea  = PW'($signed(a_q[idx]));
        eb  = PW'($signed(b_q[idx]));
        pprod_d[0][p] = ea * eb;
      end
      for (int s = 1; s < PIPE; s++) begin
        pv_d[s]    = pv_q[s-1];
        ptag_d[s]  = ptag_q[s-1];
        pprod_d[s] = pprod_q[s-1];
      end

      // A group leaving the last stage lands at its own lane indices.
      if (pv_q[PIPE-1]) begin
        for (int p = 0; p < PHYS; p++) begin
          idx = LW'(int'(ptag_q[PIPE-1]) * PHYS + p);
          {stage_ovf_d[idx], stage_res_d[idx]} = saturate(pprod_q[PIPE-1][p]);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_d     = array_mult_dataa;
            b_d     = array_mult_datab;
            grp_d   = '0;
            busy_d  = 1'b1;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (grp_q == LAST_G) begin
            grp_d   = '0;
            state_d = S_DRAIN;
          end else begin
            grp_d = grp_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (pv_q[PIPE-1] && ptag_q[PIPE-1] == LAST_G) state_d = S_DONE;
        end
        default: begin
          result_d = stage_res_q;
          ovf_d    = stage_ovf_q;
          state_d  = S_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grp_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      pv_q        <= '0;
      ptag_q      <= '0;
      pprod_q     <= '0;
      stage_res_q <= '0;
      stage_ovf_q <= '0;
      result_q    <= '0;
      ovf_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pv_q        <= pv_d;
      ptag_q      <= ptag_d;
      pprod_q     <= pprod_d;
      stage_res_q <= stage_res_d;
      stage_ovf_q <= stage_ovf_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign array_mult_result = result_q;
  assign overflow          = ovf_q;
  assign busy              = busy_q;
  assign done              = done_q & en;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_array_mult_server.sv
// Directed bench for array_mult_server: requests push expected results into a
// queue; a monitor pops and compares on every done pulse.
module tb_array_mult_server;

  localparam int LANES = 9;
  localparam int WIDTH = 27;
  localparam int EW    = LANES * WIDTH + LANES;

  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

  logic             clk;
  logic             rst;
  logic             en;
  logic             start;
  vec_t             dataa;
  vec_t             datab;
  vec_t             result;
  logic [LANES-1:0] overflow;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;
  logic [EW-1:0] exp_q[$];

  vec_t zero_v;
  vec_t v1_a, v1_b, v1_r;
  vec_t v2_a, v2_b, v2_r;
  logic [LANES-1:0] v1_o, v2_o;

  array_mult_server dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .array_mult_dataa(dataa), .array_mult_datab(datab),
    .array_mult_result(result), .overflow(overflow),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done with empty queue, required no done");
      end else begin
        e = exp_q.pop_front();
        check_val("result", 256'(result), 256'(e[LANES*WIDTH-1:0]));
        check_val("overflow", 256'(overflow), 256'(e[EW-1:LANES*WIDTH]));
      end
    end
  end

  // Driver: one request. en_low/start_mask bit k applies to edge k after acceptance.
  task automatic run_req(input string name, input vec_t a, input vec_t b,
                         input vec_t alt_a, input vec_t alt_b,
                         input vec_t exp_r, input logic [LANES-1:0] exp_o,
                         input int exp_cyc, input logic [31:0] en_low,
                         input logic [31:0] start_mask, input int rst_at);
    vec_t old_r;
    logic [LANES-1:0] old_o;
    int got;
    int d0;
    bit frozen_ok;
    got = 0;
    frozen_ok = 1'b1;
    d0 = n_done;
    old_r = result;
    old_o = overflow;
    if (rst_at == 0) exp_q.push_back({exp_o, exp_r});
    dataa = a;
    datab = b;
    en    = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dataa = alt_a;
    datab = alt_b;
    check_val({name, "_busy_rise"}, 256'(busy), 256'(1));
    for (int k = 1; k < 30; k++) begin
      en    = ~en_low[k];
      start = start_mask[k];
      rst   = (k == rst_at);
      @(posedge clk); #1;
      en    = 1'b1;
      start = 1'b0;
      if (k == rst_at) begin
        rst = 1'b0;
        check_val({name, "_rst_result"}, 256'(result), 256'(0));
        check_val({name, "_rst_overflow"}, 256'(overflow), 256'(0));
        check_val({name, "_rst_busy"}, 256'(busy), 256'(0));
        break;
      end
      if (done === 1'b1) begin
        got = k;
        break;
      end
      if (result !== old_r || overflow !== old_o) frozen_ok = 1'b0;
    end
    if (rst_at == 0) begin
      check_val({name, "_done_cycle"}, 256'(got), 256'(exp_cyc));
      check_val({name, "_frozen"}, 256'(frozen_ok), 256'(1));
      @(posedge clk); #1;
      check_val({name, "_done_pulse"}, 256'(done), 256'(0));
      check_val({name, "_busy_fall"}, 256'(busy), 256'(0));
      repeat (5) @(posedge clk);
      #1;
      check_val({name, "_done_count"}, 256'(n_done - d0), 256'(1));
    end else begin
      repeat (10) @(posedge clk);
      #1;
      check_val({name, "_no_done"}, 256'(n_done - d0), 256'(0));
      check_val({name, "_idle_busy"}, 256'(busy), 256'(0));
    end
  endtask

  initial begin
    zero_v = '0;
    // Request 1: exact products, a floor case, a negative product.
    v1_a = '0; v1_b = '0; v1_r = '0; v1_o = '0;
    v1_a[0] = 27'h0040000; v1_b[0] = 27'h0040000; v1_r[0] = 27'h0040000;
    v1_a[1] = 27'h7FA0000; v1_b[1] = 27'h0080000; v1_r[1] = 27'h7F40000;
    v1_a[2] = 27'h7FFFFFF; v1_b[2] = 27'h0020000; v1_r[2] = 27'h7FFFFFF;
    v1_a[3] = 27'h0060000; v1_b[3] = 27'h7FC0000; v1_r[3] = 27'h7FA0000;
    v1_a[8] = 27'h0010000; v1_b[8] = 27'h0010000; v1_r[8] = 27'h0004000;
    // Request 2: saturation both ways, exact-limit non-saturation, tiny floors.
    v2_a = '0; v2_b = '0; v2_r = '0;
    v2_a[0] = 27'h0040000; v2_b[0] = 27'h0040000; v2_r[0] = 27'h0040000;
    v2_a[3] = 27'h3FFFFFF; v2_b[3] = 27'h0040000; v2_r[3] = 27'h3FFFFFF;
    v2_a[4] = 27'h3FFFFFF; v2_b[4] = 27'h3FFFFFF; v2_r[4] = 27'h3FFFFFF;
    v2_a[5] = 27'h4000000; v2_b[5] = 27'h0080000; v2_r[5] = 27'h4000000;
    v2_a[6] = 27'h7FFFFFF; v2_b[6] = 27'h7FFFFFF; v2_r[6] = 27'h0000000;
    v2_a[7] = 27'h0000001; v2_b[7] = 27'h7FFFFFF; v2_r[7] = 27'h7FFFFFF;
    v2_a[8] = 27'h4000000; v2_b[8] = 27'h0040000; v2_r[8] = 27'h4000000;
    v2_o = 9'b000110000;

    rst = 1'b1; en = 1'b1; start = 1'b0; dataa = '0; datab = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_result", 256'(result), 256'(0));
    check_val("reset_overflow", 256'(overflow), 256'(0));
    check_val("reset_busy", 256'(busy), 256'(0));
    check_val("reset_done", 256'(done), 256'(0));
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("idle_result", 256'(result), 256'(0));
    check_val("idle_busy", 256'(busy), 256'(0));

    run_req("basic", v1_a, v1_b, v1_a, v1_b, v1_r, v1_o, 6, 32'h0, 32'h0, 0);
    run_req("saturate", v2_a, v2_b, v2_a, v2_b, v2_r, v2_o, 6, 32'h0, 32'h0, 0);
    run_req("reject", v1_a, v1_b, v2_a, v2_b, v1_r, v1_o, 6, 32'h0, 32'h24, 0);
    run_req("stall", v2_a, v2_b, zero_v, zero_v, v2_r, v2_o, 11, 32'h19C, 32'h0, 0);
    run_req("midrst", v1_a, v1_b, v1_a, v1_b, v1_r, v1_o, 6, 32'h0, 32'h0, 3);
    run_req("fresh", v2_a, v2_b, v2_a, v2_b, v2_r, v2_o, 6, 32'h0, 32'h0, 0);

    check_val("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
